// File: rtl/key_schedule.sv
// rtl/key_schedule.sv - iterative AES-128 round-key generator
//
// Purpose: produces one AES-128 round key per request, starting from the cipher
//   key (round 0) and expanding in place up to round NR. Only the current round
//   key is stored. Each expansion step is combinational, including its S-box
//   lookups, so a new key appears one cycle after the request.
//
// Ports:
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous active-low reset
//   start      in   1    load key_in as round key 0 (has priority over next)
//   key_in     in   128  cipher key, sampled only when start=1
//   next       in   1    advance to the next round key
//   round_key  out  128  current round key, w0 = [127:96]
//   round_idx  out  4    index of round_key, 0..NR
//   key_valid  out  1    round_key/round_idx valid
//   busy       out  1    schedule in progress
//   done       out  1    one-cycle pulse after next at round NR

module key_schedule #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         next,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         key_valid,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  // Forward AES S-box. Entry 0x00 sits in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] base;
    // ~x == 255 - x: byte x lives (255 - x) bytes above bit 0.
    base = {~x, 3'b000};
    return SBOX_TBL[base +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic {IDLE, HOLD} state_t;

  state_t       state, state_nx;
  logic [127:0] key_nx;
  logic [3:0]   idx_nx;
  logic [7:0]   rcon, rcon_nx;
  logic         done_q, done_nx;

  // One expansion step on the current round key.
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot, sub, t;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] expanded;
  logic [3:0]   idx_inc;

  always_comb begin
    w0  = round_key[127:96];
    w1  = round_key[95:64];
    w2  = round_key[63:32];
    w3  = round_key[31:0];
    rot = {w3[23:0], w3[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    t   = sub ^ {rcon, 24'h000000};
    n0  = w0 ^ t;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    expanded = {n0, n1, n2, n3};
  end

  assign idx_inc = round_idx + 4'd1;

  always_comb begin
    state_nx = state;
    key_nx   = round_key;
    idx_nx   = round_idx;
    rcon_nx  = rcon;
    done_nx  = 1'b0;
    if (start) begin
      state_nx = HOLD;
      key_nx   = key_in;
      idx_nx   = 4'd0;
      rcon_nx  = 8'h01;
    end else if (state == HOLD && next) begin
      if (round_idx < LAST_IDX) begin
        key_nx = expanded;
        idx_nx = idx_inc;
        // rcon stops at the value that produced the last key.
        if (idx_inc < LAST_IDX) begin
          rcon_nx = xtime(rcon);
        end
      end else begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      round_key <= '0;
      round_idx <= '0;
      rcon      <= 8'h01;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      round_key <= key_nx;
      round_idx <= idx_nx;
      rcon      <= rcon_nx;
      done_q    <= done_nx;
    end
  end

  assign key_valid = (state == HOLD);
  assign busy      = (state == HOLD);
  assign done      = done_q;

endmodule

// File: tb/tb_key_schedule.sv
// tb/tb_key_schedule.sv - self-checking bench for key_schedule

module tb_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, next, start1, next1;
  logic [127:0] key_in;
  logic [127:0] round_key, round_key1;
  logic [3:0]   round_idx, round_idx1;
  logic         key_valid, busy, done;
  logic         key_valid1, busy1, done1;

  always #5 clk = ~clk;

  key_schedule #(.NR(10)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .next(next),
    .round_key(round_key), .round_idx(round_idx), .key_valid(key_valid),
    .busy(busy), .done(done)
  );

  key_schedule #(.NR(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .key_in(key_in), .next(next1),
    .round_key(round_key1), .round_idx(round_idx1), .key_valid(key_valid1),
    .busy(busy1), .done(done1)
  );

  localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  int vectors = 0;
  int errors  = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] exp_rk [11];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: S-box from GF(2^8) inversion plus the affine map,
  // then the textbook 44-word expansion.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_keys(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]};
        tmp ^= {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic do_start(input logic [127:0] key);
    @(negedge clk); start = 1'b1; key_in = key;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic do_next();
    @(negedge clk); next = 1'b1;
    @(negedge clk); next = 1'b0;
  endtask

  typedef struct {
    logic [127:0] key;
    int           steps;
    logic [127:0] rk;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{KEY_A1,   0, KEY_A1};
    tbl[1] = '{KEY_A1,   1, A1_R1};
    tbl[2] = '{KEY_A1,  10, A1_R10};
    tbl[3] = '{128'h0,   0, 128'h0};
    tbl[4] = '{128'h0,   1, ZERO_R1};
    tbl[5] = '{128'h0,  10, ZERO_R10};

    rst = 1'b0; start = 1'b0; next = 1'b0; start1 = 1'b0; next1 = 1'b0; key_in = '0;
    build_sbox();
    repeat (2) @(negedge clk);
    chk("reset_key", round_key, 128'h0);
    chk("reset_idx", 128'(round_idx), 128'h0);
    chk("reset_valid", 128'(key_valid), 128'h0);
    chk("reset_busy", 128'(busy), 128'h0);
    chk("reset_done", 128'(done), 128'h0);
    rst = 1'b1;

    // Asynchronous reset in the middle of HOLD.
    do_start(KEY_A1);
    do_next();
    do_next();
    #2 rst = 1'b0;
    #1;
    chk("async_key", round_key, 128'h0);
    chk("async_idx", 128'(round_idx), 128'h0);
    chk("async_valid", 128'(key_valid), 128'h0);
    chk("async_busy", 128'(busy), 128'h0);
    @(negedge clk); rst = 1'b1;
    repeat (3) do_next();
    chk("post_reset_key", round_key, 128'h0);
    chk("post_reset_idx", 128'(round_idx), 128'h0);
    chk("post_reset_valid", 128'(key_valid), 128'h0);
    chk("post_reset_done", 128'(done), 128'h0);

    // Known-answer table.
    for (int v = 0; v < 6; v++) begin
      do_start(tbl[v].key);
      for (int s = 0; s < tbl[v].steps; s++) do_next();
      chk("tbl_key", round_key, tbl[v].rk);
      chk("tbl_idx", 128'(round_idx), 128'(tbl[v].steps));
      chk("tbl_valid", 128'(key_valid), 128'h1);
    end

    // Full A.1 schedule against the model, then the done pulse.
    model_keys(KEY_A1);
    chk("model_a1_r1", exp_rk[1], A1_R1);
    do_start(KEY_A1);
    for (int r = 1; r <= 10; r++) begin
      do_next();
      chk("a1_key", round_key, exp_rk[r]);
      chk("a1_idx", 128'(round_idx), 128'(r));
    end
    do_next();
    chk("a1_done", 128'(done), 128'h1);
    chk("a1_done_valid", 128'(key_valid), 128'h0);
    chk("a1_done_busy", 128'(busy), 128'h0);
    chk("a1_done_key", round_key, A1_R10);
    chk("a1_done_idx", 128'(round_idx), 128'd10);
    @(negedge clk);
    chk("a1_done_pulse", 128'(done), 128'h0);
    do_next();
    chk("idle_next_idx", 128'(round_idx), 128'd10);

    // Back-pressure at round 3 with key_in churning.
    do_start(KEY_A1);
    repeat (3) do_next();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      chk("hold_key", round_key, exp_rk[3]);
      chk("hold_idx", 128'(round_idx), 128'd3);
      chk("hold_valid", 128'(key_valid), 128'h1);
    end
    do_next();
    chk("hold_then_next", round_key, exp_rk[4]);

    // Restart with start and next together at round 5.
    do_start(KEY_A1);
    repeat (5) do_next();
    @(negedge clk); start = 1'b1; next = 1'b1; key_in = 128'h0;
    @(negedge clk); start = 1'b0; next = 1'b0;
    chk("restart_key", round_key, 128'h0);
    chk("restart_idx", 128'(round_idx), 128'h0);
    chk("restart_done", 128'(done), 128'h0);
    chk("restart_valid", 128'(key_valid), 128'h1);
    do_next();
    chk("restart_r1", round_key, ZERO_R1);

    // Random keys with random gaps between requests.
    for (int k = 0; k < 6; k++) begin
      logic [127:0] rkey;
      rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
      model_keys(rkey);
      do_start(rkey);
      chk("rnd_r0", round_key, exp_rk[0]);
      for (int r = 1; r <= 10; r++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        do_next();
        chk("rnd_key", round_key, exp_rk[r]);
        chk("rnd_idx", 128'(round_idx), 128'(r));
      end
      do_next();
      chk("rnd_done", 128'(done), 128'h1);
    end

    // NR=1 instance.
    @(negedge clk); start1 = 1'b1; key_in = KEY_A1;
    @(negedge clk); start1 = 1'b0;
    chk("nr1_r0", round_key1, KEY_A1);
    @(negedge clk); next1 = 1'b1;
    @(negedge clk); next1 = 1'b0;
    chk("nr1_r1", round_key1, A1_R1);
    chk("nr1_idx", 128'(round_idx1), 128'd1);
    @(negedge clk); next1 = 1'b1;
    @(negedge clk); next1 = 1'b0;
    chk("nr1_done", 128'(done1), 128'h1);
    chk("nr1_busy", 128'(busy1), 128'h0);
    chk("nr1_valid", 128'(key_valid1), 128'h0);
    @(negedge clk);
    chk("nr1_done_pulse", 128'(done1), 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
